control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired Mini SRC control unit: drives every control input of the datapath to run fetch/decode/execute.
//  Fetch is T0-T2; execute is T3..T7, chosen by opcode IR_Data[31:27].
//  Sits beside the datapath. Consumes IR_Data and CON_out; outputs are decoded from (state, opcode, wait count).
// PARAMETERS
//  MEM_WAIT  2  cycles Read is held before MDR_in captures memory data (legal range 1..7)
//  OP_W      5  opcode width
// PORTS
//  clk          in   1   system clock; all state changes on rising edge
//  clr          in   1   asynchronous active-low reset
//  IR_Data      in   32  instruction register contents
//  CON_out      in   1   branch condition flag from CON FF
//  stop         in   1   halt request, sampled only at instruction boundary
//  PC_in,IR_in,Y_in,Z_in,HI_in,LO_in,MAR_in,MDR_in,OutPort_in,IncPC  out 1 each  register load / PC-increment controls
//  PC_out,Zhigh_out,Zlow_out,HI_out,LO_out,MDR_out,InPort_out,C_out  out 1 each  bus drive selects
//  Read,Write   out  1   memory strobes
//  Gra,Grb,Grc,Rin,Rout,BAout  out 1 each  select-and-encode controls
//  RX_in_man    out  16  direct register load; only bit 15 is ever set (jal)
//  alu_instruction_bits out 5  ALU op; opcode, or ADD for address/branch arithmetic
//  run          out  1   high while executing; low in RESET and HALT
//  illegal      out  1   one-cycle pulse in T3 on an undefined opcode
// BEHAVIOUR
//  Reset: clr low -> state RESET, wait count 0; all outputs 0 and run=0 while low, whatever the clk.
//   Abort mid-instruction on reset: no Write/PC_in may follow release.
//   First edge after release -> T0.
//  Boundary: on entry to T0, if stop=1 go to HALT instead; HALT is left only by reset.
//  Fetch:
//   T0: PC_out, MAR_in, IncPC, Z_in.
//   T1: Zlow_out, PC_in, Read; MDR_in only in final wait cycle.
//   T2: MDR_out, IR_in.
//  Memory wait: any Read state stays MEM_WAIT cycles (counter 0..MEM_WAIT-1). Read is held throughout.
//  Execute (alu_instruction_bits = opcode unless noted; last step returns to T0):
//   ALU rrr (add,sub,and,or,shr,shra,shl,ror,rol): T3 Grb,Rout,Y_in | T4 Grc,Rout,Z_in | T5 Zlow_out,Gra,Rin.
//   addi/andi/ori: T3 Grb,Rout,Y_in | T4 C_out,Z_in | T5 Zlow_out,Gra,Rin.
//   neg/not: T3 Grb,Rout,Z_in | T4 Zlow_out,Gra,Rin.
//   mul/div: T3 Gra,Rout,Y_in | T4 Grb,Rout,Z_in | T5 Zlow_out,LO_in | T6 Zhigh_out,HI_in.
//   ld:
//    T3 Grb,BAout,Y_in | T4 C_out,ADD,Z_in | T5 Zlow_out,MAR_in.
//    T6 Read (+wait), MDR_in on last wait cycle | T7 MDR_out,Gra,Rin.
//   ldi: T3-T4 as ld | T5 Zlow_out,Gra,Rin.
//   st: T3-T5 as ld | T6 Gra,Rout,MDR_in (Read=0) | T7 Write, exactly one cycle.
//   br: T3 Gra,Rout (CON FF updates) | T4 PC_out,Y_in | T5 C_out,ADD,Z_in | T6 Zlow_out, PC_in only if CON_out=1.
//   jr: T3 Gra,Rout,PC_in.
//   jal: T3 PC_out,RX_in_man[15] | T4 Gra,Rout,PC_in.
//   in/out/mfhi/mflo: single T3, then T0.
//    in: InPort_out,Gra,Rin. out: Gra,Rout,OutPort_in. mfhi: HI_out,Gra,Rin. mflo: LO_out,Gra,Rin.
//   nop: T3 no controls. halt: T3 -> HALT.
//   Undefined opcode: treated as nop, illegal pulses in T3.
//  Invariants: at most one bus driver per cycle; Read and Write never both high.
//   IncPC only in T0. HALT asserts nothing.
// STRUCTURE
//  Shared package mini_src_pkg: opcode localparams, opcode-class enum, state encoding (RESET,T0..T7,HALT), ALU ADD code.
//  Sub-module instr_class_decode (combinational): opcode -> class plus illegal flag.
//  Top holds the state register, wait counter and output decode.
// TESTING
//  1 Release clr; mem[0]=add R3,R1,R2; R1=5, R2=7 -> IR loaded at T2; R3=12 after T5; PC=1; run=1.
//  2 MEM_WAIT=2; ld R1,0x55(R0); mem[0x55]=0xDEADBEEF -> Read high 2 cycles in T6; R1=0xDEADBEEF after T7.
//  3 st R2,0x10(R4); R4=0x20, R2=0xA5 -> single Write cycle with MAR=0x30, MDR=0xA5.
//  4 brzr R5,+4 at PC=8 -> R5=0: PC=13; R5=1: PC=9; PC_in low in T6 when CON_out=0.
//  5 mul R3,R4; R3=R4=0x10000 -> HI=1, LO=0; next fetch starts T0.
//  6 Halt -> run low, no Read thereafter.
//    clr low during st T6 -> Write never asserted; outputs 0 immediately; T0 follows release.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared Mini SRC definitions: opcodes, instruction classes and sequencer state encoding.
package mini_src_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Address and branch-target arithmetic reuse the ALU add operation.
    localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        CLS_ALU3, CLS_IMM, CLS_UNARY, CLS_MULDIV,
        CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
        CLS_JR, CLS_JAL, CLS_IN, CLS_OUT,
        CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } op_class_e;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/condition inputs and every datapath control line.
interface control_sequencer_if;
    import mini_src_pkg::*;

    logic [31:0]     IR_Data;
    logic            CON_out;
    logic            stop;
    logic            PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
    logic            PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic            Read, Write;
    logic            Gra, Grb, Grc, Rin, Rout, BAout;
    logic [15:0]     RX_in_man;
    logic [OP_W-1:0] alu_instruction_bits;
    logic            run;
    logic            illegal;

    modport master (
        input  IR_Data, CON_out, stop,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
        output RX_in_man, alu_instruction_bits, run, illegal
    );

    modport slave (
        output IR_Data, CON_out, stop,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
        input  RX_in_man, alu_instruction_bits, run, illegal
    );
endinterface

// File: rtl/control_sequencer_decode.sv
// Opcode classifier: groups opcodes that share an execute sequence; unknown opcodes run as nop.
module instr_class_decode
    import mini_src_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output op_class_e       op_class,
    output logic            illegal
);

    // Opcode to class lookup
    always_comb begin
        op_class = CLS_NOP;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      op_class = CLS_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:             op_class = CLS_IMM;
            OP_NEG, OP_NOT:                       op_class = CLS_UNARY;
            OP_MUL, OP_DIV:                       op_class = CLS_MULDIV;
            OP_LD:                                op_class = CLS_LD;
            OP_LDI:                               op_class = CLS_LDI;
            OP_ST:                                op_class = CLS_ST;
            OP_BR:                                op_class = CLS_BR;
            OP_JR:                                op_class = CLS_JR;
            OP_JAL:                               op_class = CLS_JAL;
            OP_IN:                                op_class = CLS_IN;
            OP_OUT:                               op_class = CLS_OUT;
            OP_MFHI:                              op_class = CLS_MFHI;
            OP_MFLO:                              op_class = CLS_MFLO;
            OP_NOP:                               op_class = CLS_NOP;
            OP_HALT:                              op_class = CLS_HALT;
            default: begin
                op_class = CLS_NOP;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2, opcode-dependent execute T3-T7, memory wait counting.
module control_sequencer
    import mini_src_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master ctl
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_e          state_q, state_d;
    state_e          boundary_s;
    logic [2:0]      wait_q, wait_d;
    logic [OP_W-1:0] opcode_s;
    op_class_e       op_class_s;
    logic            op_illegal_s;
    logic            last_wait_s;

    assign opcode_s    = ctl.IR_Data[31:27];
    assign last_wait_s = (wait_q == WAIT_LAST);

    instr_class_decode u_decode (
        .opcode   (opcode_s),
        .op_class (op_class_s),
        .illegal  (op_illegal_s)
    );

    // State and wait-count registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RESET;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state: stop is only honoured where the next step would be T0
    always_comb begin
        state_d    = state_q;
        wait_d     = 3'd0;
        boundary_s = ctl.stop ? S_HALT : S_T0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1: begin
                if (last_wait_s) begin
                    state_d = S_T2;
                end else begin
                    state_d = S_T1;
                    wait_d  = wait_q + 3'd1;
                end
            end
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (op_class_s)
                    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI,
                    CLS_MFLO, CLS_NOP:                state_d = boundary_s;
                    CLS_HALT:                         state_d = S_HALT;
                    default:                          state_d = S_T4;
                endcase
            end
            S_T4: begin
                case (op_class_s)
                    CLS_UNARY, CLS_JAL:               state_d = boundary_s;
                    default:                          state_d = S_T5;
                endcase
            end
            S_T5: begin
                case (op_class_s)
                    CLS_ALU3, CLS_IMM, CLS_LDI:       state_d = boundary_s;
                    default:                          state_d = S_T6;
                endcase
            end
            S_T6: begin
                case (op_class_s)
                    CLS_LD: begin
                        if (last_wait_s) begin
                            state_d = S_T7;
                        end else begin
                            state_d = S_T6;
                            wait_d  = wait_q + 3'd1;
                        end
                    end
                    CLS_ST:                           state_d = S_T7;
                    default:                          state_d = boundary_s;
                endcase
            end
            S_T7:    state_d = boundary_s;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Control decode from state, instruction class and wait count
    always_comb begin
        {ctl.PC_in, ctl.IR_in, ctl.Y_in, ctl.Z_in, ctl.HI_in, ctl.LO_in,
         ctl.MAR_in, ctl.MDR_in, ctl.OutPort_in, ctl.IncPC}                 = 10'd0;
        {ctl.PC_out, ctl.Zhigh_out, ctl.Zlow_out, ctl.HI_out, ctl.LO_out,
         ctl.MDR_out, ctl.InPort_out, ctl.C_out}                            = 8'd0;
        {ctl.Read, ctl.Write}                                               = 2'd0;
        {ctl.Gra, ctl.Grb, ctl.Grc, ctl.Rin, ctl.Rout, ctl.BAout}           = 6'd0;
        ctl.RX_in_man            = 16'd0;
        ctl.alu_instruction_bits = 5'd0;
        ctl.illegal              = 1'b0;
        ctl.run                  = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: {ctl.PC_out, ctl.MAR_in, ctl.IncPC, ctl.Z_in} = 4'hF;
            S_T1: begin
                {ctl.Zlow_out, ctl.PC_in, ctl.Read} = 3'b111;
                ctl.MDR_in = last_wait_s;
            end
            S_T2: {ctl.MDR_out, ctl.IR_in} = 2'b11;
            S_T3: begin
                ctl.alu_instruction_bits = opcode_s;
                ctl.illegal              = op_illegal_s;
                case (op_class_s)
                    CLS_ALU3, CLS_IMM:       {ctl.Grb, ctl.Rout, ctl.Y_in}     = 3'b111;
                    CLS_UNARY:               {ctl.Grb, ctl.Rout, ctl.Z_in}     = 3'b111;
                    CLS_MULDIV:              {ctl.Gra, ctl.Rout, ctl.Y_in}     = 3'b111;
                    CLS_LD, CLS_LDI, CLS_ST: {ctl.Grb, ctl.BAout, ctl.Y_in}    = 3'b111;
                    CLS_BR:                  {ctl.Gra, ctl.Rout}               = 2'b11;
                    CLS_JR:                  {ctl.Gra, ctl.Rout, ctl.PC_in}    = 3'b111;
                    CLS_JAL: begin
                        ctl.PC_out        = 1'b1;
                        ctl.RX_in_man[15] = 1'b1;
                    end
                    CLS_IN:   {ctl.InPort_out, ctl.Gra, ctl.Rin}               = 3'b111;
                    CLS_OUT:  {ctl.Gra, ctl.Rout, ctl.OutPort_in}              = 3'b111;
                    CLS_MFHI: {ctl.HI_out, ctl.Gra, ctl.Rin}                   = 3'b111;
                    CLS_MFLO: {ctl.LO_out, ctl.Gra, ctl.Rin}                   = 3'b111;
                    default: ;
                endcase
            end
            S_T4: begin
                ctl.alu_instruction_bits = opcode_s;
                case (op_class_s)
                    CLS_ALU3:   {ctl.Grc, ctl.Rout, ctl.Z_in}                  = 3'b111;
                    CLS_IMM:    {ctl.C_out, ctl.Z_in}                          = 2'b11;
                    CLS_UNARY:  {ctl.Zlow_out, ctl.Gra, ctl.Rin}               = 3'b111;
                    CLS_MULDIV: {ctl.Grb, ctl.Rout, ctl.Z_in}                  = 3'b111;
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        {ctl.C_out, ctl.Z_in}    = 2'b11;
                        ctl.alu_instruction_bits = ALU_ADD;
                    end
                    CLS_BR:     {ctl.PC_out, ctl.Y_in}                         = 2'b11;
                    CLS_JAL:    {ctl.Gra, ctl.Rout, ctl.PC_in}                 = 3'b111;
                    default: ;
                endcase
            end
            S_T5: begin
                ctl.alu_instruction_bits = opcode_s;
                case (op_class_s)
                    CLS_ALU3, CLS_IMM, CLS_LDI: {ctl.Zlow_out, ctl.Gra, ctl.Rin} = 3'b111;
                    CLS_MULDIV:                 {ctl.Zlow_out, ctl.LO_in}        = 2'b11;
                    CLS_LD, CLS_ST:             {ctl.Zlow_out, ctl.MAR_in}       = 2'b11;
                    CLS_BR: begin
                        {ctl.C_out, ctl.Z_in}    = 2'b11;
                        ctl.alu_instruction_bits = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                ctl.alu_instruction_bits = opcode_s;
                case (op_class_s)
                    CLS_MULDIV: {ctl.Zhigh_out, ctl.HI_in} = 2'b11;
                    CLS_LD: begin
                        ctl.Read   = 1'b1;
                        ctl.MDR_in = last_wait_s;
                    end
                    CLS_ST:     {ctl.Gra, ctl.Rout, ctl.MDR_in} = 3'b111;
                    CLS_BR: begin
                        ctl.Zlow_out = 1'b1;
                        ctl.PC_in    = ctl.CON_out;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                ctl.alu_instruction_bits = opcode_s;
                case (op_class_s)
                    CLS_LD:  {ctl.MDR_out, ctl.Gra, ctl.Rin} = 3'b111;
                    CLS_ST:  ctl.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
